// File: rtl/robs_mult_seq.sv
// Sequential Robertson's multiplier, one add/shift step per clock.
// Signed or unsigned operands selected per operation; 2*WIDTH-bit exact product.
module robs_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               mode_q, mode_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               last;
    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     ext_y;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;

    // Final signed step subtracts Y: the multiplier MSB carries weight -2^(W-1).
    always_comb begin
        last   = (cnt_q == CW'(WIDTH - 1));
        ext_a  = {mode_q & a_q[WIDTH-1], a_q};
        ext_y  = {mode_q & y_q[WIDTH-1], y_q};
        addend = '0;
        if (x_q[0]) begin
            addend = (mode_q && last) ? -ext_y : ext_y;
        end
        sum = ext_a + addend;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = '0;
                    x_d     = multiplier;
                    y_d     = multiplicand;
                    mode_d  = signed_mode;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = sum[WIDTH:1];
                x_d   = {sum[0], x_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    prod_d  = {sum[WIDTH:1], sum[0], x_q[WIDTH-1:1]};
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_robs_mult_seq.sv
// Bench for robs_mult_seq: directed table at WIDTH=8, corner sequences,
// and randomized WIDTH=16 run against an arithmetic reference.
module tb_robs_mult_seq;

    logic        clk = 1'b0;
    logic        reset;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] prod8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] x16, y16;
    logic [31:0] prod16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    robs_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .multiplier(x8), .multiplicand(y8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    robs_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
        .multiplier(x16), .multiplicand(y16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    typedef struct {
        logic        sm;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // lat counts cycles from the cycle start is driven to the done cycle
    task automatic run8(input logic sm, input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] p, output int lat);
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; x8 = x; y8 = y;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        x8 = 8'($urandom);
        y8 = 8'($urandom);
        sm8 = ~sm;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = prod8;
    endtask

    task automatic run16(input logic sm, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] p, output int lat);
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; x16 = x; y16 = y;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        x16 = 16'($urandom);
        y16 = 16'($urandom);
        lat = 1;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        p = prod16;
    endtask

    function automatic logic [31:0] ref16(input logic sm, input logic [15:0] x,
                                          input logic [15:0] y);
        longint a, b;
        a = sm ? longint'($signed(x)) : longint'(x);
        b = sm ? longint'($signed(y)) : longint'(y);
        return 32'(a * b);
    endfunction

    initial begin
        logic [15:0] p8;
        logic [31:0] p16;
        int          lat;
        int          cnt;

        vecs[0]  = '{1'b1, 8'd6,   8'hFD, 16'hFFEE};
        vecs[1]  = '{1'b1, 8'h80,  8'h80, 16'h4000};
        vecs[2]  = '{1'b1, 8'h80,  8'h7F, 16'hC080};
        vecs[3]  = '{1'b0, 8'hFF,  8'hFF, 16'hFE01};
        vecs[4]  = '{1'b1, 8'hFF,  8'hFF, 16'h0001};
        vecs[5]  = '{1'b0, 8'h00,  8'h00, 16'h0000};
        vecs[6]  = '{1'b0, 8'h80,  8'h02, 16'h0100};
        vecs[7]  = '{1'b1, 8'h7F,  8'h7F, 16'h3F01};
        vecs[8]  = '{1'b1, 8'h01,  8'h80, 16'hFF80};
        vecs[9]  = '{1'b0, 8'd200, 8'd3,  16'h0258};
        vecs[10] = '{1'b1, 8'hFF,  8'h05, 16'hFFFB};
        vecs[11] = '{1'b1, 8'h05,  8'hFF, 16'hFFFB};

        reset = 1'b1;
        start8 = 0; sm8 = 0; x8 = 0; y8 = 0;
        start16 = 0; sm16 = 0; x16 = 0; y16 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_prod8", 64'(prod8), 64'd0);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_prod16", 64'(prod16), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run8(vecs[i].sm, vecs[i].x, vecs[i].y, p8, lat);
            check($sformatf("vec%0d_prod", i), 64'(p8), 64'(vecs[i].exp));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd9);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 64'(done8), 64'd0);
        end

        // product must hold while a new operation runs
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; x8 = 8'd3; y8 = 8'd4;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_busy", 64'(busy8), 64'd1);
        check("hold_prod", 64'(prod8), 64'hFFFB);
        cnt = 4;
        while (!done8 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("hold_new_prod", 64'(prod8), 64'h000C);

        // back-to-back with start held and toggled during RUN
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; x8 = 8'd7; y8 = 8'd9;
        @(posedge clk);
        @(negedge clk);
        x8 = 8'hFB; y8 = 8'd5;
        cnt = 1;
        while (!done8 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_first_prod", 64'(prod8), 64'h003F);
        check("b2b_first_lat", 64'(cnt), 64'd9);
        @(negedge clk);
        check("b2b_no_idle_busy", 64'(busy8), 64'd1);
        check("b2b_no_idle_done", 64'(done8), 64'd0);
        cnt = 1;
        forever begin
            if (done8 || cnt >= 40) break;
            start8 = cnt[0];
            x8 = 8'($urandom);
            y8 = 8'($urandom);
            @(negedge clk);
            cnt++;
        end
        start8 = 1'b0;
        check("b2b_second_prod", 64'(prod8), 64'hFFE7);
        check("b2b_second_gap", 64'(cnt), 64'd9);
        @(negedge clk);
        check("b2b_idle_after", 64'(busy8), 64'd0);

        // async reset while count==4
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; x8 = 8'd10; y8 = 8'd10;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 64'(busy8), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_prod", 64'(prod8), 64'd0);
        #1 reset = 1'b0;
        run8(1'b0, 8'd10, 8'd10, p8, lat);
        check("post_rst_prod", 64'(p8), 64'h0064);
        check("post_rst_lat", 64'(lat), 64'd9);

        for (int i = 0; i < 2000; i++) begin
            logic        sm;
            logic [15:0] a, b;
            sm = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if (i < 4) begin
                a = (i[0]) ? 16'h8000 : 16'hFFFF;
                b = (i[1]) ? 16'h8000 : 16'h7FFF;
                sm = 1'b1;
            end
            run16(sm, a, b, p16, lat);
            check($sformatf("r16_%0d_prod", i), 64'(p16), 64'(ref16(sm, a, b)));
            @(negedge clk);
            check($sformatf("r16_%0d_done_width", i), 64'(done16), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
